// File: rtl/axis_frame_gate_pkg.sv
// Shared types for the axis_frame_gate frame-capture block.
package axis_frame_gate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLDOFF = 2'd3
    } gate_state_t;

endpackage

// File: rtl/axis_frame_gate_trig.sv
// Level-crossing detector: registered previous sample plus a signed/unsigned
// comparator. trig is combinational on the current sample.
module axis_frame_gate_trig #(
    parameter int    AXIS_TDATA_WIDTH  = 16,
    parameter string AXIS_TDATA_SIGNED = "FALSE"
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] sample,
    input  logic                        sample_valid,
    input  logic [AXIS_TDATA_WIDTH-1:0] level,
    output logic                        trig
);

    localparam bit IS_SIGNED = (AXIS_TDATA_SIGNED == "TRUE");

    logic [AXIS_TDATA_WIDTH-1:0] prev_r;
    logic                        prev_valid_r;
    logic                        below_s;
    logic                        above_s;

    // Track the most recent accepted sample, free-running across all states.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prev_r       <= {AXIS_TDATA_WIDTH{1'b0}};
            prev_valid_r <= 1'b0;
        end else if (sample_valid) begin
            prev_r       <= sample;
            prev_valid_r <= 1'b1;
        end else begin
            prev_r       <= prev_r;
            prev_valid_r <= prev_valid_r;
        end
    end

    // Rising crossing: previous strictly below level, current at or above it.
    always_comb begin
        below_s = 1'b0;
        above_s = 1'b0;
        if (IS_SIGNED) begin
            below_s = $signed(prev_r) < $signed(level);
            above_s = $signed(sample) >= $signed(level);
        end else begin
            below_s = prev_r < level;
            above_s = sample >= level;
        end
        trig = prev_valid_r & below_s & above_s;
    end

endmodule

// File: rtl/axis_frame_gate.sv
// Triggered frame gate for a free-running AXI-Stream sample source.
// Optional macro AXIS_FRAME_GATE_HOLDOFF_EN adds a post-frame holdoff state.
module axis_frame_gate
    import axis_frame_gate_pkg::*;
#(
    parameter int    AXIS_TDATA_WIDTH  = 16,
    parameter int    CNTR_WIDTH        = 16,
    parameter string AXIS_TDATA_SIGNED = "FALSE"
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        cfg_start,
    input  logic                        cfg_abort,
    input  logic [AXIS_TDATA_WIDTH-1:0] cfg_level,
    input  logic [CNTR_WIDTH-1:0]       cfg_frame_len,
    input  logic [CNTR_WIDTH-1:0]       cfg_frame_num,
`ifdef AXIS_FRAME_GATE_HOLDOFF_EN
    input  logic [CNTR_WIDTH-1:0]       cfg_holdoff,
`endif
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        sts_busy,
    output logic                        sts_done,
    output logic [CNTR_WIDTH-1:0]       sts_frames,
    output logic                        sts_overrun
);

    localparam logic [CNTR_WIDTH-1:0] CNT_ZERO = {CNTR_WIDTH{1'b0}};
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

    gate_state_t                 state_r;
    gate_state_t                 after_frame_s;
    logic [CNTR_WIDTH-1:0]       len_r;
    logic [CNTR_WIDTH-1:0]       num_r;
    logic [CNTR_WIDTH-1:0]       cnt_r;
    logic [AXIS_TDATA_WIDTH-1:0] level_r;
    logic                        trig_s;
    logic                        fwd_s;
    logic                        eof_s;
    logic                        last_frame_s;
`ifdef AXIS_FRAME_GATE_HOLDOFF_EN
    logic [CNTR_WIDTH-1:0]       holdoff_r;
    logic [CNTR_WIDTH-1:0]       hold_cnt_r;
`endif

    assign s_axis_tready = 1'b1;

    axis_frame_gate_trig #(
        .AXIS_TDATA_WIDTH  (AXIS_TDATA_WIDTH),
        .AXIS_TDATA_SIGNED (AXIS_TDATA_SIGNED)
    ) u_trig (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .sample       (s_axis_tdata),
        .sample_valid (s_axis_tvalid),
        .level        (level_r),
        .trig         (trig_s)
    );

    // Forward/end-of-frame decode; cnt_r is 0 while ARMED so len==1 ends the frame on the trigger sample.
    always_comb begin
        fwd_s         = 1'b0;
        after_frame_s = ST_ARMED;
        case (state_r)
            ST_ARMED:   fwd_s = s_axis_tvalid & trig_s;
            ST_CAPTURE: fwd_s = s_axis_tvalid;
            default:    fwd_s = 1'b0;
        endcase
        eof_s        = fwd_s & ((cnt_r + CNT_ONE) == len_r);
        last_frame_s = (sts_frames + CNT_ONE) == num_r;
`ifdef AXIS_FRAME_GATE_HOLDOFF_EN
        if (holdoff_r != CNT_ZERO) begin
            after_frame_s = ST_HOLDOFF;
        end else begin
            after_frame_s = ST_ARMED;
        end
`endif
    end

    // Main FSM with registered stream and status outputs; abort has top priority.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r       <= ST_IDLE;
            len_r         <= CNT_ZERO;
            num_r         <= CNT_ZERO;
            cnt_r         <= CNT_ZERO;
            level_r       <= {AXIS_TDATA_WIDTH{1'b0}};
            m_axis_tdata  <= {AXIS_TDATA_WIDTH{1'b0}};
            m_axis_tvalid <= 1'b0;
            sts_busy      <= 1'b0;
            sts_done      <= 1'b0;
            sts_frames    <= CNT_ZERO;
            sts_overrun   <= 1'b0;
`ifdef AXIS_FRAME_GATE_HOLDOFF_EN
            holdoff_r     <= CNT_ZERO;
            hold_cnt_r    <= CNT_ZERO;
`endif
        end else begin
            sts_done      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            if (m_axis_tvalid && !m_axis_tready) begin
                sts_overrun <= 1'b1;
            end
            if (cfg_abort) begin
                state_r  <= ST_IDLE;
                sts_busy <= 1'b0;
                cnt_r    <= CNT_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (cfg_start) begin
                            len_r       <= cfg_frame_len;
                            num_r       <= cfg_frame_num;
                            level_r     <= cfg_level;
                            cnt_r       <= CNT_ZERO;
                            sts_frames  <= CNT_ZERO;
                            sts_overrun <= 1'b0;
`ifdef AXIS_FRAME_GATE_HOLDOFF_EN
                            holdoff_r   <= cfg_holdoff;
                            hold_cnt_r  <= CNT_ZERO;
`endif
                            if ((cfg_frame_len == CNT_ZERO) || (cfg_frame_num == CNT_ZERO)) begin
                                sts_done <= 1'b1;
                            end else begin
                                state_r  <= ST_ARMED;
                                sts_busy <= 1'b1;
                            end
                        end
                    end
                    ST_ARMED, ST_CAPTURE: begin
                        if (fwd_s) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= s_axis_tdata;
                            if (eof_s) begin
                                sts_frames <= sts_frames + CNT_ONE;
                                cnt_r      <= CNT_ZERO;
                                if (last_frame_s) begin
                                    state_r  <= ST_IDLE;
                                    sts_busy <= 1'b0;
                                    sts_done <= 1'b1;
                                end else begin
                                    state_r <= after_frame_s;
                                end
                            end else begin
                                cnt_r   <= cnt_r + CNT_ONE;
                                state_r <= ST_CAPTURE;
                            end
                        end
                    end
`ifdef AXIS_FRAME_GATE_HOLDOFF_EN
                    ST_HOLDOFF: begin
                        if (s_axis_tvalid) begin
                            if ((hold_cnt_r + CNT_ONE) == holdoff_r) begin
                                hold_cnt_r <= CNT_ZERO;
                                state_r    <= ST_ARMED;
                            end else begin
                                hold_cnt_r <= hold_cnt_r + CNT_ONE;
                            end
                        end
                    end
`endif
                    default: begin
                        state_r  <= ST_IDLE;
                        sts_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/axis_frame_gate.md
Name: axis_frame_gate

Overview:
- Upstream stage of the averaging chain. Watches a free-running ADC sample stream, arms on a start pulse and waits for a level-crossing trigger.
- On each trigger, forwards exactly cfg_frame_len consecutive samples as one frame, repeating for cfg_frame_num frames, then idles.
- Its output drives the averager's slave port, which counts samples per frame and expects gap-free frames.

Parameters:
- AXIS_TDATA_WIDTH, 16, sample width on both AXI-Stream ports.
- CNTR_WIDTH, 16, width of sample and frame counters and of cfg_frame_len/cfg_frame_num.
- AXIS_TDATA_SIGNED, "FALSE", "TRUE" selects signed level comparison; otherwise unsigned.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cfg_start  in  1  start pulse; one-cycle high arms the gate.
- cfg_abort  in  1  abort pulse; returns to IDLE.
- cfg_level  in  AXIS_TDATA_WIDTH  trigger threshold.
- cfg_frame_len  in  CNTR_WIDTH  samples per frame.
- cfg_frame_num  in  CNTR_WIDTH  frames per run.
- s_axis_tready  out  1  tied 1.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  ADC sample.
- s_axis_tvalid  in  1  sample valid.
- m_axis_tready  in  1  downstream ready (monitored only).
- m_axis_tdata  out  AXIS_TDATA_WIDTH  gated sample.
- m_axis_tvalid  out  1  gated sample valid.
- sts_busy  out  1  high in ARMED/CAPTURE.
- sts_done  out  1  one-cycle pulse at run completion.
- sts_frames  out  CNTR_WIDTH  frames completed in current/last run.
- sts_overrun  out  1  sticky; set if m_axis_tvalid & ~m_axis_tready.

Behaviour:
- Interface: one clock aclk; reset is asynchronous and active-low on aresetn. Asserting aresetn low immediately clears all state and outputs, including mid-frame.
- Reset values: state=IDLE; m_axis_tvalid=0; m_axis_tdata=0; sts_busy=0; sts_done=0; sts_frames=0; sts_overrun=0; prev-sample register=0; prev_valid=0.
- Sample bookkeeping: every accepted sample (s_axis_tvalid=1) updates prev-sample and sets prev_valid.
- Trigger condition: prev_valid & prev < cfg_level & cur >= cfg_level, using signed or unsigned compare per AXIS_TDATA_SIGNED.
- States:
  - IDLE: on cfg_start, latch cfg_frame_len, cfg_frame_num and cfg_level. Clear sts_frames and sts_overrun. Go to ARMED. If the latched len or num is 0, stay in IDLE and pulse sts_done.
  - ARMED: on an accepted sample meeting the trigger, that sample is frame sample 0; set sample cntr=1 and go to CAPTURE. If len==1, apply the CAPTURE end-of-frame rule on this same sample.
  - CAPTURE: every accepted sample is forwarded and increments the sample counter. On the sample where cntr+1==len (end of frame), sts_frames increments. If sts_frames+1==num, go to IDLE and pulse sts_done; otherwise go to ARMED.
- Output timing: forwarded sample appears on m_axis_tdata with m_axis_tvalid=1 exactly one cycle after acceptance (registered). m_axis_tvalid=0 otherwise. Samples with s_axis_tvalid=0 do not advance counters.
- Retriggering: crossings during CAPTURE are ignored. Re-arming uses prev from the last frame sample, so a crossing on the very next sample triggers.
- Control precedence: cfg_start is ignored unless in IDLE. cfg_abort in any state → IDLE next cycle, with no sts_done. cfg_abort and cfg_start in the same cycle: abort wins. An aborted partial frame is truncated, and sts_frames keeps the completed-frame count.
- Counter arithmetic: counters are CNTR_WIDTH wide and never wrap within a run. len and num max out at 2^CNTR_WIDTH-1.
- Overrun: m_axis_tready is never used to stall. Overrun is sticky until the next accepted cfg_start.

Optional Feature:
- Macro AXIS_FRAME_GATE_HOLDOFF_EN.
- Defined: adds input cfg_holdoff [CNTR_WIDTH-1:0], latched at start, and a HOLDOFF state between CAPTURE and ARMED. Stays there for cfg_holdoff accepted samples (0 = straight to ARMED); prev-sample still updates. cfg_abort is honoured in HOLDOFF.
- Undefined: no port, no state; CAPTURE goes directly to ARMED.

Decomposition:
- Shared package: state enum (IDLE, ARMED, CAPTURE, HOLDOFF).
- One sub-module, axis_frame_gate_trig: registered prev-sample plus signed/unsigned crossing comparator, outputs a combinational trig flag.

Test Plan:
- Basic frame: len=4, num=1, level=100, ramp 90,95,...,130 → trigger on 100; output 100,105,110,115 one cycle after each input; sts_done one pulse; sts_frames=1.
- Multi-frame: len=3, num=3, sawtooth 0..200 step 50 → three 3-sample frames, each starting at 100; sts_frames=3; no output between frames.
- Signed: AXIS_TDATA_SIGNED="TRUE", level=-10, samples -20,-5 → triggers. Unsigned build with 0xFFEC,0xFFFB and level 0xFFF6 also triggers, while 0x0005 after 0xFFEC does not.
- Gaps and abort: s_axis_tvalid toggling 1,0,1 → counters advance only on valid samples. cfg_abort mid-frame → IDLE next cycle, no sts_done, sts_frames unchanged. Abort+start in the same cycle → stays IDLE.
- Edge cases: len=0 → sts_done pulse, no output. m_axis_tready=0 during a frame → sts_overrun=1 held until the next start. aresetn low mid-frame → all outputs 0 immediately.
- HOLDOFF_EN: holdoff=5 with crossings 2 samples after frame end → ignored; next crossing after the 5th sample triggers.
